// File: rtl/dram_resp_encoder.sv
`default_nettype none
// ============================================================================
// Module   : dram_resp_encoder
// Purpose  : Re-encodes bank/row/column completions into flat L2 addresses
//            and returns them to L2 through a small valid/ready FIFO.
// Option   : DRAM_RESP_PARITY_EN - store and drive even parity per entry.
// Revision : 1.0 - initial release
// ============================================================================
module dram_resp_encoder #(
    parameter int ADDR_WIDTH   = 13,
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmpl_valid,
    output logic                            cmpl_ready,
    input  logic [$clog2(NUM_OF_BANKS)-1:0] cmpl_bank_id,
    input  logic [$clog2(NUM_OF_ROWS)-1:0]  cmpl_row_id,
    input  logic [$clog2(NUM_OF_COLS)-1:0]  cmpl_col_id,
    input  logic                            cmpl_is_write,
    input  logic [DATA_WIDTH-1:0]           cmpl_data,
    output logic                            l2_resp_valid,
    input  logic                            l2_resp_ready,
    output logic [ADDR_WIDTH-1:0]           l2_resp_address,
    output logic                            l2_resp_is_write,
    output logic [DATA_WIDTH-1:0]           l2_resp_data,
    output logic                            l2_resp_parity,
    output logic [$clog2(DEPTH):0]          fifo_count
);

    localparam int c_bank_w = $clog2(NUM_OF_BANKS);
    localparam int c_row_w  = $clog2(NUM_OF_ROWS);
    localparam int c_col_w  = $clog2(NUM_OF_COLS);
    localparam int c_ptr_w  = $clog2(DEPTH);
    localparam int c_cnt_w  = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

    if (ADDR_WIDTH != c_bank_w + c_row_w + c_col_w) begin : g_bad_addr_width
        $error("ADDR_WIDTH must equal bank + row + column index widths");
    end
    if (DEPTH < 2 || (1 << c_ptr_w) != DEPTH) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end

    // FIFO bookkeeping
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    logic               push, pop;

    // Entry storage
    logic [ADDR_WIDTH-1:0] mem_addr_q [DEPTH];
    logic                  mem_wr_q   [DEPTH];
    logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];

    // Registered head of the FIFO, which drives the L2 response port
    logic [ADDR_WIDTH-1:0] head_addr_q, head_addr_d;
    logic                  head_wr_q,   head_wr_d;
    logic [DATA_WIDTH-1:0] head_data_q, head_data_d;

    // Encoded incoming completion
    logic [ADDR_WIDTH-1:0] enc_addr;
    logic [DATA_WIDTH-1:0] enc_data;
    logic                  head_from_enc;

    always_comb begin
        enc_addr = {cmpl_bank_id, cmpl_row_id, cmpl_col_id};
        enc_data = cmpl_is_write ? '0 : cmpl_data;
    end

    assign cmpl_ready    = (count_q != c_full);
    assign l2_resp_valid = (count_q != '0);
    assign push          = cmpl_valid && cmpl_ready;
    assign pop           = l2_resp_valid && l2_resp_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // The new head is the entry being written this cycle when it lands on the
    // slot the read pointer moves to; otherwise it already sits in storage.
    assign head_from_enc = push && (wr_ptr_q == rd_ptr_d);

    always_comb begin
        head_addr_d = head_addr_q;
        head_wr_d   = head_wr_q;
        head_data_d = head_data_q;
        if (count_d != '0) begin
            if (head_from_enc) begin
                head_addr_d = enc_addr;
                head_wr_d   = cmpl_is_write;
                head_data_d = enc_data;
            end else begin
                head_addr_d = mem_addr_q[rd_ptr_d];
                head_wr_d   = mem_wr_q[rd_ptr_d];
                head_data_d = mem_data_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            head_addr_q <= '0;
            head_wr_q   <= 1'b0;
            head_data_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            head_addr_q <= head_addr_d;
            head_wr_q   <= head_wr_d;
            head_data_q <= head_data_d;
        end
    end

    // Storage needs no reset: nothing is read from a slot before it is written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr_q[wr_ptr_q] <= enc_addr;
            mem_wr_q[wr_ptr_q]   <= cmpl_is_write;
            mem_data_q[wr_ptr_q] <= enc_data;
        end
    end

`ifdef DRAM_RESP_PARITY_EN
    logic mem_par_q [DEPTH];
    logic head_par_q, head_par_d;
    logic enc_par;

    assign enc_par = ^{enc_addr, cmpl_is_write, enc_data};

    always_comb begin
        head_par_d = head_par_q;
        if (count_d != '0) begin
            head_par_d = head_from_enc ? enc_par : mem_par_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_par_q <= 1'b0;
        end else begin
            head_par_q <= head_par_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_par_q[wr_ptr_q] <= enc_par;
        end
    end

    assign l2_resp_parity = head_par_q;
`else
    assign l2_resp_parity = 1'b0;
`endif

    assign l2_resp_address  = head_addr_q;
    assign l2_resp_is_write = head_wr_q;
    assign l2_resp_data     = head_data_q;
    assign fifo_count       = count_q;

endmodule
`default_nettype wire

// File: tb/tb_dram_resp_encoder.sv
`default_nettype none
// Testbench for dram_resp_encoder: queue-based reference model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_dram_resp_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmpl_valid;
    logic        cmpl_ready;
    logic [2:0]  cmpl_bank_id;
    logic [6:0]  cmpl_row_id;
    logic [2:0]  cmpl_col_id;
    logic        cmpl_is_write;
    logic [31:0] cmpl_data;
    logic        l2_resp_valid;
    logic        l2_resp_ready;
    logic [12:0] l2_resp_address;
    logic        l2_resp_is_write;
    logic [31:0] l2_resp_data;
    logic        l2_resp_parity;
    logic [2:0]  fifo_count;

    dram_resp_encoder dut (
        .clk              (clk),
        .rst              (rst),
        .cmpl_valid       (cmpl_valid),
        .cmpl_ready       (cmpl_ready),
        .cmpl_bank_id     (cmpl_bank_id),
        .cmpl_row_id      (cmpl_row_id),
        .cmpl_col_id      (cmpl_col_id),
        .cmpl_is_write    (cmpl_is_write),
        .cmpl_data        (cmpl_data),
        .l2_resp_valid    (l2_resp_valid),
        .l2_resp_ready    (l2_resp_ready),
        .l2_resp_address  (l2_resp_address),
        .l2_resp_is_write (l2_resp_is_write),
        .l2_resp_data     (l2_resp_data),
        .l2_resp_parity   (l2_resp_parity),
        .fifo_count       (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [12:0] addr;
        logic        iw;
        logic [31:0] data;
        logic        par;
    } ent_t;

    ent_t q[$];
    int   total = 0;
    int   bad   = 0;

`ifdef DRAM_RESP_PARITY_EN
    localparam logic PAR_FIRST = 1'b1;
`else
    localparam logic PAR_FIRST = 1'b0;
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic ent_t mk(input int b, input int r, input int c,
                                input logic w, input logic [31:0] d);
        ent_t e;
        int   ones;
        e.addr = 13'(b * 128 * 8 + r * 8 + c);
        e.iw   = w;
        e.data = w ? 32'h0 : d;
        ones   = $countones(e.addr) + $countones(e.data) + (w ? 1 : 0);
`ifdef DRAM_RESP_PARITY_EN
        e.par  = (ones % 2) == 1;
`else
        e.par  = 1'b0;
        if (ones < 0) e.par = 1'b1;
`endif
        return e;
    endfunction

    // Reference model: occupancy and order only, from the handshake rules.
    always @(posedge clk or posedge rst) begin : model
        bit pu, po;
        if (rst) begin
            q.delete();
        end else begin
            pu = cmpl_valid && (q.size() < DEPTH);
            po = l2_resp_ready && (q.size() > 0);
            if (po) void'(q.pop_front());
            if (pu) q.push_back(mk(int'(cmpl_bank_id), int'(cmpl_row_id),
                                   int'(cmpl_col_id), cmpl_is_write, cmpl_data));
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_count", 64'(fifo_count), 64'(q.size()));
            chk("model_cmpl_ready", 64'(cmpl_ready), 64'(q.size() != DEPTH));
            chk("model_valid", 64'(l2_resp_valid), 64'(q.size() != 0));
            if (q.size() > 0) begin
                chk("model_addr", 64'(l2_resp_address), 64'(q[0].addr));
                chk("model_is_write", 64'(l2_resp_is_write), 64'(q[0].iw));
                chk("model_data", 64'(l2_resp_data), 64'(q[0].data));
                chk("model_parity", 64'(l2_resp_parity), 64'(q[0].par));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_cmpl(input int b, input int r, input int c,
                            input logic w, input logic [31:0] d);
        cmpl_valid    = 1'b1;
        cmpl_bank_id  = 3'(b);
        cmpl_row_id   = 7'(r);
        cmpl_col_id   = 3'(c);
        cmpl_is_write = w;
        cmpl_data     = d;
    endtask

    task automatic push(input int b, input int r, input int c,
                        input logic w, input logic [31:0] d);
        set_cmpl(b, r, c, w, d);
        @(negedge clk);
    endtask

    initial begin
        rst           = 1'b1;
        cmpl_valid    = 1'b0;
        cmpl_bank_id  = '0;
        cmpl_row_id   = '0;
        cmpl_col_id   = '0;
        cmpl_is_write = 1'b0;
        cmpl_data     = '0;
        l2_resp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_cmpl_ready", 64'(cmpl_ready), 64'd1);
        chk("rst_valid", 64'(l2_resp_valid), 64'd0);
        chk("rst_addr", 64'(l2_resp_address), 64'd0);
        chk("rst_data", 64'(l2_resp_data), 64'd0);
        chk("rst_is_write", 64'(l2_resp_is_write), 64'd0);
        chk("rst_parity", 64'(l2_resp_parity), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single read: bank 5, row 0x2A, column 3
        push(5, 'h2A, 3, 1'b0, 32'h0);
        cmpl_valid = 1'b0;
        chk("t1_valid", 64'(l2_resp_valid), 64'd1);
        chk("t1_addr", 64'(l2_resp_address), 64'h1553);
        chk("t1_is_write", 64'(l2_resp_is_write), 64'd0);
        chk("t1_parity", 64'(l2_resp_parity), 64'(PAR_FIRST));
        l2_resp_ready = 1'b1;
        @(negedge clk);

        // Write ack then read, consumer always ready
        push(7, 127, 7, 1'b1, 32'h1234_5678);
        chk("t2_first_addr", 64'(l2_resp_address), 64'h1FFF);
        chk("t2_first_is_write", 64'(l2_resp_is_write), 64'd1);
        chk("t2_first_data", 64'(l2_resp_data), 64'd0);
        push(0, 0, 0, 1'b0, 32'hDEAD_BEEF);
        cmpl_valid = 1'b0;
        chk("t2_second_addr", 64'(l2_resp_address), 64'h0000);
        chk("t2_second_data", 64'(l2_resp_data), 64'hDEAD_BEEF);
        @(negedge clk);
        chk("t2_drained", 64'(fifo_count), 64'd0);
        l2_resp_ready = 1'b0;

        // Head stable while the consumer stalls: 2*1024 + 0x55*8 + 6 = 0xAAE
        push(2, 'h55, 6, 1'b0, 32'hCAFE_F00D);
        cmpl_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_valid", 64'(l2_resp_valid), 64'd1);
            chk("t6_addr", 64'(l2_resp_address), 64'hAAE);
            chk("t6_data", 64'(l2_resp_data), 64'hCAFE_F00D);
        end
        l2_resp_ready = 1'b1;
        @(negedge clk);
        l2_resp_ready = 1'b0;

        // Fill to full, fifth completion stalls until one pop
        for (int i = 0; i < 4; i++) push(i + 1, i * 31, 7 - i, i[0], 32'h100 + i);
        set_cmpl(6, 99, 1, 1'b0, 32'h5555_AAAA);
        @(negedge clk);
        chk("t3_full_count", 64'(fifo_count), 64'd4);
        chk("t3_full_ready", 64'(cmpl_ready), 64'd0);
        l2_resp_ready = 1'b1;
        @(negedge clk);
        chk("t3_after_pop_count", 64'(fifo_count), 64'd3);
        l2_resp_ready = 1'b0;
        @(negedge clk);
        cmpl_valid = 1'b0;
        chk("t3_fifth_accepted", 64'(fifo_count), 64'd4);

        // Drain to 2, then steady push+pop for 10 cycles
        l2_resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            push(i % 8, (i * 13) % 128, (i * 3) % 8, i[0], 32'h1000 + i);
            chk("t4_steady_count", 64'(fifo_count), 64'd2);
        end
        cmpl_valid    = 1'b0;
        l2_resp_ready = 1'b0;
        push(4, 17, 2, 1'b0, 32'h7777_0000);
        cmpl_valid = 1'b0;
        chk("t5_pre_count", 64'(fifo_count), 64'd3);

        // Asynchronous reset mid-burst
        set_cmpl(1, 1, 1, 1'b0, 32'h1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_count", 64'(fifo_count), 64'd0);
        chk("t5_async_valid", 64'(l2_resp_valid), 64'd0);
        chk("t5_async_ready", 64'(cmpl_ready), 64'd1);
        chk("t5_async_addr", 64'(l2_resp_address), 64'd0);
        chk("t5_async_data", 64'(l2_resp_data), 64'd0);
        @(negedge clk);
        cmpl_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        // 3*1024 + 0x11*8 + 5 = 0xC8D
        push(3, 'h11, 5, 1'b0, 32'hA5A5_0001);
        cmpl_valid = 1'b0;
        chk("t5_post_addr", 64'(l2_resp_address), 64'hC8D);
        chk("t5_post_data", 64'(l2_resp_data), 64'hA5A5_0001);
        chk("t5_post_count", 64'(fifo_count), 64'd1);
        l2_resp_ready = 1'b1;
        @(negedge clk);
        l2_resp_ready = 1'b0;
        chk("end_count", 64'(fifo_count), 64'd0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
